// File: rtl/strum_event_controller.sv
`timescale 1ns/1ps
// Strum-to-judge sequencer: debounces strum, latches the chord, runs a tick-timed
// hit window against the lane intersections and queues hit/miss events for the processor.
module strum_event_controller #(
   parameter int unsigned DEBOUNCE_CYCLES  = 1000000,
   parameter int unsigned HIT_WINDOW_TICKS = 6,
   parameter int unsigned FIFO_DEPTH       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       game_tick,
   input  logic [3:0] buttons,
   input  logic [3:0] intersections,
   input  logic       strum,
   output logic       evt_valid,
   output logic [7:0] evt_data,
   input  logic       evt_ack,
   output logic       overflow,
   output logic       busy
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [DW-1:0] DMAX      = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]    WCNT_INIT = 4'(HIT_WINDOW_TICKS);

   typedef enum logic [1:0] {IDLE, WINDOW, JUDGE} state_t;

   logic          strum_m_q, strum_s_q;
   logic [3:0]    btn_m_q, btn_s_q;
   logic [DW-1:0] dcnt_q;
   logic          strum_db_q, strum_db_prev_q;
   logic          strum_evt;

   state_t        state_q;
   logic [3:0]    chord_q, seen_q, wcnt_q;
   logic [3:0]    seen_n;
   logic          hit_q, busy_q, overflow_q;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic          full, push, pop, push_ok;
   logic [7:0]    evt_word;

   always_ff @(posedge clk) begin
      if (!reset) begin
         strum_m_q <= 1'b0;
         strum_s_q <= 1'b0;
         btn_m_q   <= '0;
         btn_s_q   <= '0;
      end else begin
         strum_m_q <= strum;
         strum_s_q <= strum_m_q;
         btn_m_q   <= buttons;
         btn_s_q   <= btn_m_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         dcnt_q          <= '0;
         strum_db_q      <= 1'b0;
         strum_db_prev_q <= 1'b0;
      end else begin
         strum_db_prev_q <= strum_db_q;
         if (strum_s_q == strum_db_q) begin
            dcnt_q <= '0;
         end else if (dcnt_q == DMAX) begin
            strum_db_q <= strum_s_q;
            dcnt_q     <= '0;
         end else begin
            dcnt_q <= dcnt_q + 1'b1;
         end
      end
   end

   assign strum_evt = strum_db_q & ~strum_db_prev_q;
   assign seen_n    = seen_q | intersections;

   assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign evt_valid = (wptr_q != rptr_q);
   assign pop      = evt_valid & evt_ack;
   assign push     = (state_q == JUDGE);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign push_ok  = push & (~full | pop);
   assign evt_word = {hit_q, (chord_q == 4'd0), 2'b00, chord_q};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         chord_q    <= '0;
         seen_q     <= '0;
         wcnt_q     <= '0;
         hit_q      <= 1'b0;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (strum_evt) begin
                  chord_q <= btn_s_q;
                  seen_q  <= '0;
                  wcnt_q  <= WCNT_INIT;
                  state_q <= WINDOW;
                  busy_q  <= 1'b1;
               end
            end
            WINDOW: begin
               seen_q <= seen_n;
               if ((chord_q != 4'd0) && ((seen_n & chord_q) == chord_q)) begin
                  hit_q   <= 1'b1;
                  state_q <= JUDGE;
               end else if (game_tick && (wcnt_q == 4'd1)) begin
                  hit_q   <= 1'b0;
                  state_q <= JUDGE;
               end else if (game_tick) begin
                  wcnt_q <= wcnt_q - 1'b1;
               end
            end
            JUDGE: begin
               if (!push_ok) overflow_q <= 1'b1;
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push_ok) wptr_d = wptr_q + (AW+1)'(1);
      if (pop)     rptr_d = rptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q[AW-1:0]] <= evt_word;
   end

   assign evt_data = evt_valid ? mem_q[rptr_q[AW-1:0]] : '0;
   assign overflow = overflow_q;
   assign busy     = busy_q;

endmodule
